key_expander: RTL and testbench

KEY_EXPANDER -- requirements
Module: key_expander

---
 rtl/aes_pkg.sv | 34 +++
 rtl/aes_sbox.sv | 21 ++
 rtl/key_expander.sv | 136 +++++++++++++
 tb/tb_key_expander.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, FSM state encoding and round constants.
package aes_pkg;

    localparam int WORD_W     = 32;
    localparam int KEY_W      = 128;
    localparam int NUM_WORDS  = 44;
    localparam int NUM_ROUNDS = 11;

    localparam logic [5:0] LAST_WORD = 6'd43;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] round);
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational FIPS-197 forward S-box.
module aes_sbox (
    input  logic [7:0] sub_in,
    output logic [7:0] sub_out
);

    // Row 0 of the table sits in the top bits, so byte k starts at bit 8*(255-k).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub_out = SBOX_TABLE[{~sub_in, 3'b000} +: 8];

endmodule

// File: rtl/key_expander.sv
// AES-128 key expander: four key words are loaded, then w[4..43] are generated in place.
// Define KEY_EXPANDER_SHARED_SBOX_EN to time-multiplex one S-box (80-cycle expansion).
module key_expander
    import aes_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              key_word_valid,
    input  logic [WORD_W-1:0] key_word,
    input  logic [3:0]        round_sel,
    output logic              key_ready,
    output logic              key_expand_done,
    output logic [KEY_W-1:0]  round_key,
    output logic [1:0]        dbg_state,
    output logic [5:0]        dbg_word_idx
);

    state_e            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [WORD_W-1:0] w_q [NUM_WORDS];

    logic              wr_en;
    logic [5:0]        wr_idx;
    logic [WORD_W-1:0] wr_data;
    logic [WORD_W-1:0] prev_word, back_word, rot_word, sub_word, temp;
    logic              sub_ready;

    assign prev_word = w_q[idx_q - 6'd1];
    assign back_word = w_q[idx_q - 6'd4];
    assign rot_word  = {prev_word[23:0], prev_word[31:24]};
    assign temp      = (idx_q[1:0] == 2'b00) ? (sub_word ^ {rcon(idx_q[5:2]), 24'h0}) : prev_word;

`ifdef KEY_EXPANDER_SHARED_SBOX_EN
    logic [2:0]        sub_cnt_q;
    logic [WORD_W-1:0] sub_acc_q;
    logic [7:0]        sbox_in, sbox_out;

    always_comb begin
        case (sub_cnt_q[1:0])
            2'd0:    sbox_in = rot_word[31:24];
            2'd1:    sbox_in = rot_word[23:16];
            2'd2:    sbox_in = rot_word[15:8];
            default: sbox_in = rot_word[7:0];
        endcase
    end

    aes_sbox u_sbox (.sub_in(sbox_in), .sub_out(sbox_out));

    // Four cycles shift substituted bytes in MSB-first; the fifth cycle performs the write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_cnt_q <= '0;
            sub_acc_q <= '0;
        end else if (state_q == EXPAND && idx_q[1:0] == 2'b00) begin
            if (sub_cnt_q == 3'd4) begin
                sub_cnt_q <= '0;
            end else begin
                sub_cnt_q <= sub_cnt_q + 3'd1;
                sub_acc_q <= {sub_acc_q[23:0], sbox_out};
            end
        end
    end

    assign sub_word  = sub_acc_q;
    assign sub_ready = (idx_q[1:0] != 2'b00) || (sub_cnt_q == 3'd4);
`else
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.sub_in(rot_word[8*b +: 8]), .sub_out(sub_word[8*b +: 8]));
    end

    assign sub_ready = 1'b1;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_idx  = idx_q;
        wr_data = key_word;
        case (state_q)
            IDLE, LOAD: begin
                if (key_word_valid) begin
                    wr_en   = 1'b1;
                    idx_d   = idx_q + 6'd1;
                    state_d = (idx_q == 6'd3) ? EXPAND : LOAD;
                end
            end
            EXPAND: begin
                if (sub_ready) begin
                    wr_en   = 1'b1;
                    wr_data = back_word ^ temp;
                    idx_d   = idx_q + 6'd1;
                    if (idx_q == LAST_WORD) state_d = DONE;
                end
            end
            DONE: begin
                if (key_word_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = 6'd0;
                    idx_d   = 6'd1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            // NOTE: the word store is reset because round_key must read zero after reset.
            for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            if (wr_en) w_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        round_key = '0;
        if (int'(round_sel) < NUM_ROUNDS) begin
            round_key = {w_q[{round_sel, 2'b00}], w_q[{round_sel, 2'b01}],
                         w_q[{round_sel, 2'b10}], w_q[{round_sel, 2'b11}]};
        end
    end

    assign key_ready       = (state_q != EXPAND);
    assign key_expand_done = (state_q == DONE);
    assign dbg_state       = state_q;
    assign dbg_word_idx    = idx_q;

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander: stimulus queues expected round keys, a monitor checks on done.
module tb_key_expander;

`ifdef KEY_EXPANDER_SHARED_SBOX_EN
    localparam int LAT = 80;
`else
    localparam int LAT = 40;
`endif

    localparam logic [127:0] STD_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] STD_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] STD_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        int           w3_cyc;
        logic [127:0] rk0;
        logic [127:0] rk1;
        logic [127:0] rk10;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         key_word_valid = 1'b0;
    logic [31:0]  key_word = '0;
    logic [3:0]   round_sel;
    logic         key_ready;
    logic         key_expand_done;
    logic [127:0] round_key;
    logic [1:0]   dbg_state;
    logic [5:0]   dbg_word_idx;

    logic [3:0]   stim_sel = '0;
    logic [3:0]   mon_sel = '0;
    bit           mon_busy = 1'b0;
    int           cyc = 0;
    int           last_w3 = 0;
    int           n_cmp = 0;
    int           n_err = 0;
    exp_t         exp_q[$];

    assign round_sel = mon_busy ? mon_sel : stim_sel;

    key_expander dut (
        .clock          (clock),
        .reset          (reset),
        .key_word_valid (key_word_valid),
        .key_word       (key_word),
        .round_sel      (round_sel),
        .key_ready      (key_ready),
        .key_expand_done(key_expand_done),
        .round_key      (round_key),
        .dbg_state      (dbg_state),
        .dbg_word_idx   (dbg_word_idx)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; last_w3 records the edge that accepted the fourth word.
    task automatic load_key(input logic [127:0] key, input bit check_drop);
        for (int i = 0; i < 4; i++) begin
            key_word_valid = 1'b1;
            key_word       = key[127 - 32*i -: 32];
            @(negedge clock);
            if (check_drop && i == 0) check("done_drop", 128'(key_expand_done), 128'(0));
        end
        key_word_valid = 1'b0;
        key_word       = '0;
        last_w3        = cyc;
    endtask

    task automatic expect_keys(input logic [127:0] rk0, input logic [127:0] rk1, input logic [127:0] rk10);
        exp_t e;
        e.w3_cyc = last_w3;
        e.rk0    = rk0;
        e.rk1    = rk1;
        e.rk10   = rk10;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("idle_wait", 128'(exp_q.size() == 0 && !mon_busy), 128'(1));
    endtask

    // Monitor: on every rising edge of done, pop the oldest expectation and check latency and keys.
    initial begin
        exp_t e;
        logic done_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (key_expand_done && !done_prev) begin
                check("done_has_expect", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    mon_busy = 1'b1;
                    check("done_latency", 128'(cyc - e.w3_cyc), 128'(LAT));
                    mon_sel = 4'd0;  #1 check("rk0", round_key, e.rk0);
                    mon_sel = 4'd1;  #1 check("rk1", round_key, e.rk1);
                    mon_sel = 4'd10; #1 check("rk10", round_key, e.rk10);
                    mon_sel = 4'd12; #1 check("rk12", round_key, 128'(0));
                    mon_busy = 1'b0;
                end
            end
            done_prev = key_expand_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clock);
        check("rst_state", 128'(dbg_state), 128'(0));
        check("rst_idx", 128'(dbg_word_idx), 128'(0));
        check("rst_ready", 128'(key_ready), 128'(1));
        check("rst_done", 128'(key_expand_done), 128'(0));
        check("rst_rk0", round_key, 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // FIPS-197 key
        load_key(STD_KEY, 1'b0);
        check("expand_state", 128'(dbg_state), 128'(2));
        check("expand_idx", 128'(dbg_word_idx), 128'(4));
        expect_keys(STD_KEY, STD_RK1, STD_RK10);
        wait_idle(LAT + 20);
        check("done_idx", 128'(dbg_word_idx), 128'(44));
        check("done_ready", 128'(key_ready), 128'(1));
        check("done_held", 128'(key_expand_done), 128'(1));

        // Restart from DONE with the all-zero key
        load_key(128'(0), 1'b1);
        expect_keys(128'(0), ZERO_RK1, ZERO_RK10);
        wait_idle(LAT + 20);

        // Writes offered during EXPAND are ignored and key_ready stays low
        load_key(STD_KEY, 1'b0);
        expect_keys(STD_KEY, STD_RK1, STD_RK10);
        for (int j = 0; j < LAT; j++) begin
            check("expand_ready_low", 128'(key_ready), 128'(0));
            key_word_valid = (j % 2 == 0);
            key_word       = 32'hffffffff;
            @(negedge clock);
        end
        key_word_valid = 1'b0;
        key_word       = '0;
        wait_idle(20);

        // Reset ten cycles into EXPAND discards everything
        load_key(128'(0), 1'b0);
        repeat (10) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_state", 128'(dbg_state), 128'(0));
        check("abort_idx", 128'(dbg_word_idx), 128'(0));
        check("abort_done", 128'(key_expand_done), 128'(0));
        check("abort_ready", 128'(key_ready), 128'(1));
        for (int s = 0; s < 16; s++) begin
            stim_sel = 4'(s);
            #1 check("abort_rk_zero", round_key, 128'(0));
        end
        stim_sel = '0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Fresh load after the abort completes normally
        load_key(STD_KEY, 1'b0);
        expect_keys(STD_KEY, STD_RK1, STD_RK10);
        wait_idle(LAT + 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
